// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game engine: direction/state codes,
// LFSR seed and taps, and the start-of-game positions.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_UP    = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  // Fibonacci taps 16,14,13,11 mapped onto bits 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int head_x0(input int gw); return gw / 2; endfunction
  function automatic int head_y0(input int gh); return gh / 2; endfunction
  function automatic int food_x0(input int gw); return gw / 4; endfunction
  function automatic int food_y0(input int gh); return gh / 4; endfunction

endpackage

// File: rtl/snake_game_core_if.sv
// Control strobes, pixel query and status bundle of the snake engine.
interface snake_game_core_if #(
  parameter int SCORE_W = 8,
  parameter int LEN_W   = 5
);
  logic               tick, start, turn_cw, turn_ccw;
  logic [9:0]         pix_x, pix_y;
  logic               pix_head, pix_food, pix_body;
  logic               playing, game_over;
  logic [SCORE_W-1:0] score, high_score;
  logic [LEN_W-1:0]   length;

  modport master (
    output tick, start, turn_cw, turn_ccw, pix_x, pix_y,
    input  pix_head, pix_food, pix_body, playing, game_over, score, high_score, length
  );
  modport slave (
    input  tick, start, turn_cw, turn_ccw, pix_x, pix_y,
    output pix_head, pix_food, pix_body, playing, game_over, score, high_score, length
  );
endinterface

// File: rtl/snake_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used to place food.
module snake_lfsr16
  import snake_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr_o
);
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  assign lfsr_o = lfsr_q;

  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
endmodule

// File: rtl/snake_game_core.sv
// Grid snake engine: head + body shift register stepped on tick, wall/self
// collision, pseudo-random food, and a registered per-pixel cell lookup.
module snake_game_core
  import snake_pkg::*;
#(
  parameter int GRID_W     = 40,
  parameter int GRID_H     = 30,
  parameter int XW         = 6,
  parameter int YW         = 5,
  parameter int CELL_SHIFT = 4,
  parameter int MAX_LEN    = 16,
  parameter int SCORE_W    = 8
) (
  input logic              clk,
  input logic              reset,
  snake_game_core_if.slave bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [XW-1:0] HX0 = XW'(head_x0(GRID_W));
  localparam logic [YW-1:0] HY0 = YW'(head_y0(GRID_H));
  localparam logic [XW-1:0] FX0 = XW'(food_x0(GRID_W));
  localparam logic [YW-1:0] FY0 = YW'(food_y0(GRID_H));

  state_e state_q, state_d;
  dir_e   dir_q, dir_d;
  logic [XW-1:0] hx_q, hx_d, fx_q, fx_d, nx, cand_x, lx;
  logic [YW-1:0] hy_q, hy_d, fy_q, fy_d, ny, cand_y, ly;
  logic [MAX_LEN-1:0][XW-1:0] bx_q, bx_d;
  logic [MAX_LEN-1:0][YW-1:0] by_q, by_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [SCORE_W-1:0] score_q, score_d, hi_q, hi_d;
  logic [15:0] lfsr;
  logic        unused_lfsr;
  logic        wall, self_hit, eat;
  logic [9:0]  cell_x, cell_y;
  logic        act, in_grid, h_hit, f_hit, b_hit;
  logic        ph_q, pf_q, pb_q;

  snake_lfsr16 u_lfsr (.clk(clk), .rst(reset), .lfsr_o(lfsr));
  assign unused_lfsr = ^lfsr;

  // Fold the raw LFSR fields into the grid with a single conditional subtract
  assign lx     = lfsr[XW-1:0];
  assign ly     = lfsr[8 +: YW];
  assign cand_x = ({1'b0, lx} >= (XW+1)'(GRID_W)) ? lx - XW'(GRID_W) : lx;
  assign cand_y = ({1'b0, ly} >= (YW+1)'(GRID_H)) ? ly - YW'(GRID_H) : ly;

  always_comb begin
    nx   = hx_q;
    ny   = hy_q;
    wall = 1'b0;
    unique case (dir_q)
      DIR_RIGHT: begin wall = (hx_q == XW'(GRID_W - 1)); nx = hx_q + XW'(1); end
      DIR_DOWN:  begin wall = (hy_q == YW'(GRID_H - 1)); ny = hy_q + YW'(1); end
      DIR_LEFT:  begin wall = (hx_q == '0);              nx = hx_q - XW'(1); end
      default:   begin wall = (hy_q == '0);              ny = hy_q - YW'(1); end
    endcase
  end

  assign eat    = (nx == fx_q) && (ny == fy_q);
  assign cell_x = bus.pix_x >> CELL_SHIFT;
  assign cell_y = bus.pix_y >> CELL_SHIFT;

  // Same MAX_LEN comparator bank pattern for next-head and pixel-cell lookups
  always_comb begin
    self_hit = 1'b0;
    b_hit    = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (int'(len_q) > i && bx_q[i] == nx && by_q[i] == ny) self_hit = 1'b1;
      if (int'(len_q) > i && 10'(bx_q[i]) == cell_x && 10'(by_q[i]) == cell_y) b_hit = 1'b1;
    end
  end

  assign act     = (state_q != ST_IDLE);
  assign in_grid = (cell_x < 10'(GRID_W)) && (cell_y < 10'(GRID_H));
  assign h_hit   = (cell_x == 10'(hx_q)) && (cell_y == 10'(hy_q));
  assign f_hit   = (cell_x == 10'(fx_q)) && (cell_y == 10'(fy_q));

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    hx_d    = hx_q;
    hy_d    = hy_q;
    fx_d    = fx_q;
    fy_d    = fy_q;
    bx_d    = bx_q;
    by_d    = by_q;
    len_d   = len_q;
    score_d = score_q;
    hi_d    = hi_q;
    unique case (state_q)
      ST_RUN: begin
        if (bus.turn_cw && !bus.turn_ccw)      dir_d = dir_e'(dir_q + 2'd1);
        else if (bus.turn_ccw && !bus.turn_cw) dir_d = dir_e'(dir_q - 2'd1);
        if (bus.tick) begin
          if (wall || self_hit) begin
            state_d = ST_OVER;
            if (score_q > hi_q) hi_d = score_q;
          end else begin
            bx_d = {bx_q[MAX_LEN-2:0], hx_q};
            by_d = {by_q[MAX_LEN-2:0], hy_q};
            hx_d = nx;
            hy_d = ny;
            if (eat) begin
              len_d   = (len_q == LEN_W'(MAX_LEN)) ? len_q : len_q + LEN_W'(1);
              score_d = (&score_q) ? score_q : score_q + SCORE_W'(1);
              fx_d    = cand_x;
              fy_d    = cand_y;
            end
          end
        end
      end
      default: begin
        if (bus.start) begin
          state_d = ST_RUN;
          dir_d   = DIR_RIGHT;
          hx_d    = HX0;
          hy_d    = HY0;
          fx_d    = FX0;
          fy_d    = FY0;
          len_d   = '0;
          score_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_RIGHT;
      hx_q    <= HX0;
      hy_q    <= HY0;
      fx_q    <= FX0;
      fy_q    <= FY0;
      bx_q    <= '0;
      by_q    <= '0;
      len_q   <= '0;
      score_q <= '0;
      hi_q    <= '0;
      ph_q    <= 1'b0;
      pf_q    <= 1'b0;
      pb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      hx_q    <= hx_d;
      hy_q    <= hy_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      len_q   <= len_d;
      score_q <= score_d;
      hi_q    <= hi_d;
      ph_q    <= act && in_grid && h_hit;
      pf_q    <= act && in_grid && !h_hit && f_hit;
      pb_q    <= act && in_grid && !h_hit && !f_hit && b_hit;
    end
  end

  assign bus.pix_head   = ph_q;
  assign bus.pix_food   = pf_q;
  assign bus.pix_body   = pb_q;
  assign bus.playing    = (state_q == ST_RUN);
  assign bus.game_over  = (state_q == ST_OVER);
  assign bus.score      = score_q;
  assign bus.high_score = hi_q;
  assign bus.length     = len_q;
endmodule

// File: tb/tb_snake_game_core.sv
// Scoreboard bench: a behavioural game model predicts every output each cycle.
module tb_snake_game_core;
  localparam int GW = 40, GH = 30, MAXL = 16, SW = 8, LW = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  snake_game_core_if #(.SCORE_W(SW), .LEN_W(LW)) bus ();
  snake_game_core #(.GRID_W(GW), .GRID_H(GH), .XW(6), .YW(5), .CELL_SHIFT(4),
                    .MAX_LEN(MAXL), .SCORE_W(SW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0, n_fail = 0;
  int m_state, m_hx, m_hy, m_dir, m_len, m_fx, m_fy, m_score, m_hi;
  int m_bx[MAXL], m_by[MAXL];
  int q_px = 700, q_py = 10;
  int hi_saved;
  logic [15:0] m_lfsr;

  typedef struct { int play, over, score, hi, len, ph, pf, pb; } exp_t;
  exp_t sb[$];

  always @(posedge clk or posedge reset)
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic int ddx(input int d); return d == 0 ? 1 : (d == 2 ? -1 : 0); endfunction
  function automatic int ddy(input int d); return d == 1 ? 1 : (d == 3 ? -1 : 0); endfunction
  function automatic int iabs(input int v); return v < 0 ? -v : v; endfunction

  function automatic int in_body(input int x, input int y);
    for (int i = 0; i < m_len; i++) if (m_bx[i] == x && m_by[i] == y) return 1;
    return 0;
  endfunction

  function automatic int safe(input int d);
    int x, y;
    x = m_hx + ddx(d);
    y = m_hy + ddy(d);
    return (x >= 0 && x < GW && y >= 0 && y < GH && !in_body(x, y)) ? 1 : 0;
  endfunction

  task automatic m_reset();
    m_state = 0; m_hx = 20; m_hy = 15; m_dir = 0; m_len = 0;
    m_fx = 10; m_fy = 7; m_score = 0; m_hi = 0;
    for (int i = 0; i < MAXL; i++) begin m_bx[i] = 0; m_by[i] = 0; end
  endtask

  task automatic model_pix(output int ph, output int pf, output int pb);
    int cx, cy;
    cx = q_px >> 4; cy = q_py >> 4;
    ph = 0; pf = 0; pb = 0;
    if (m_state != 0 && cx < GW && cy < GH) begin
      if (cx == m_hx && cy == m_hy)      ph = 1;
      else if (cx == m_fx && cy == m_fy) pf = 1;
      else                               pb = in_body(cx, cy);
    end
  endtask

  task automatic model_step(input bit t, input bit s, input bit cw, input bit ccw);
    int nx, ny, cx, cy;
    if (m_state != 1) begin
      if (s) begin
        m_state = 1; m_hx = 20; m_hy = 15; m_dir = 0; m_len = 0;
        m_fx = 10; m_fy = 7; m_score = 0;
      end
    end else begin
      if (t) begin
        nx = m_hx + ddx(m_dir);
        ny = m_hy + ddy(m_dir);
        if (nx < 0 || nx >= GW || ny < 0 || ny >= GH || in_body(nx, ny)) begin
          m_state = 2;
          if (m_score > m_hi) m_hi = m_score;
        end else begin
          for (int i = MAXL - 1; i > 0; i--) begin m_bx[i] = m_bx[i-1]; m_by[i] = m_by[i-1]; end
          m_bx[0] = m_hx; m_by[0] = m_hy;
          m_hx = nx; m_hy = ny;
          if (nx == m_fx && ny == m_fy) begin
            if (m_len < MAXL) m_len++;
            if (m_score < 255) m_score++;
            cx = int'(m_lfsr[5:0]);  if (cx >= GW) cx -= GW;
            cy = int'(m_lfsr[12:8]); if (cy >= GH) cy -= GH;
            m_fx = cx; m_fy = cy;
          end
        end
      end
      if (cw && !ccw)      m_dir = (m_dir + 1) % 4;
      else if (ccw && !cw) m_dir = (m_dir + 3) % 4;
    end
  endtask

  // Called at a negedge: drive one cycle of stimulus, predict, then compare
  task automatic cycle(input bit t, input bit s, input bit cw, input bit ccw);
    exp_t e;
    bus.tick = t; bus.start = s; bus.turn_cw = cw; bus.turn_ccw = ccw;
    bus.pix_x = 10'(q_px); bus.pix_y = 10'(q_py);
    model_pix(e.ph, e.pf, e.pb);
    model_step(t, s, cw, ccw);
    e.play = (m_state == 1); e.over = (m_state == 2);
    e.score = m_score; e.hi = m_hi; e.len = m_len;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk("playing", bus.playing, e.play);
    chk("game_over", bus.game_over, e.over);
    chk("score", bus.score, e.score);
    chk("high_score", bus.high_score, e.hi);
    chk("length", bus.length, e.len);
    chk("pix_head", bus.pix_head, e.ph);
    chk("pix_food", bus.pix_food, e.pf);
    chk("pix_body", bus.pix_body, e.pb);
  endtask

  task automatic tick1(); cycle(1, 0, 0, 0); endtask
  task automatic query(input int cx, input int cy); q_px = cx * 16 + 3; q_py = cy * 16 + 5; endtask

  // Greedy step toward a target that never reverses and never enters the body
  task automatic nav_step(input int tx, input int ty);
    int ord[3];
    int pick, cur;
    pick = -1;
    cur = iabs(m_hx - tx) + iabs(m_hy - ty);
    ord[0] = m_dir; ord[1] = (m_dir + 1) % 4; ord[2] = (m_dir + 3) % 4;
    for (int k = 0; k < 3; k++)
      if (pick < 0 && safe(ord[k]) &&
          iabs(m_hx + ddx(ord[k]) - tx) + iabs(m_hy + ddy(ord[k]) - ty) < cur) pick = ord[k];
    for (int k = 0; k < 3; k++) if (pick < 0 && safe(ord[k])) pick = ord[k];
    if (pick < 0) pick = m_dir;
    if (pick == (m_dir + 1) % 4)      cycle(0, 0, 1, 0);
    else if (pick == (m_dir + 3) % 4) cycle(0, 0, 0, 1);
    tick1();
  endtask

  initial begin
    bus.tick = 0; bus.start = 0; bus.turn_cw = 0; bus.turn_ccw = 0;
    bus.pix_x = 10'd700; bus.pix_y = 10'd10;
    m_reset();
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_playing", bus.playing, 0);
    chk("rst_over", bus.game_over, 0);
    chk("rst_score", bus.score, 0);
    chk("rst_hi", bus.high_score, 0);
    chk("rst_len", bus.length, 0);
    chk("rst_pix", {bus.pix_head, bus.pix_food, bus.pix_body}, 0);
    reset = 1'b0;

    // IDLE ignores tick/turn and shows no pixels
    q_px = 322; q_py = 242;
    cycle(1, 0, 1, 0);
    cycle(0, 0, 0, 0);
    chk("idle_pix_head", bus.pix_head, 0);

    // start + 5 ticks right
    cycle(0, 1, 0, 0);
    repeat (5) tick1();
    query(25, 15); cycle(0, 0, 0, 0);
    chk("head_25_15", bus.pix_head, 1);
    chk("run_playing", bus.playing, 1);
    chk("run_score0", bus.score, 0);
    cycle(0, 1, 0, 0);

    // asynchronous reset mid-game
    @(posedge clk); #2 reset = 1'b1; #1;
    chk("arst_playing", bus.playing, 0);
    chk("arst_len", bus.length, 0);
    m_reset();
    @(negedge clk); reset = 1'b0;

    // walk up then left onto the initial food at (10,7)
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 1);
    repeat (8) tick1();
    cycle(0, 0, 0, 1);
    repeat (10) tick1();
    chk("eat_score", bus.score, 1);
    chk("eat_len", bus.length, 1);
    query(10, 7); cycle(0, 0, 0, 0);
    chk("eat_head", bus.pix_head, 1);
    query(11, 7); cycle(0, 0, 0, 0);
    chk("eat_body0", bus.pix_body, 1);
    query(m_fx, m_fy); cycle(0, 0, 0, 0);

    // up one, then right into the east wall
    cycle(0, 0, 1, 0); tick1();
    cycle(0, 0, 1, 0);
    repeat (29) tick1();
    query(39, 6);
    tick1();
    cycle(0, 0, 0, 0);
    chk("wall_over", bus.game_over, 1);
    chk("wall_head_kept", bus.pix_head, 1);
    chk("wall_hi", bus.high_score, m_score);
    hi_saved = m_hi;

    // restart keeps high score
    cycle(0, 1, 0, 0);
    chk("restart_score", bus.score, 0);
    chk("restart_hi", bus.high_score, hi_saved);
    q_px = 322; q_py = 242; cycle(0, 0, 0, 0);
    chk("q322_head", bus.pix_head, 1);
    q_px = 160; q_py = 112; cycle(0, 0, 0, 0);
    chk("q160_food", bus.pix_food, 1);
    q_px = 700; q_py = 10; cycle(0, 0, 0, 0);
    chk("q700_none", {bus.pix_head, bus.pix_food, bus.pix_body}, 0);

    // both turns cancel
    cycle(0, 0, 1, 1); tick1();
    query(21, 15); cycle(0, 0, 0, 0);
    chk("both_turn_head", bus.pix_head, 1);

    // grow to length 3, line up moving right, then curl into body[2]
    for (int n = 0; n < 400 && m_state == 1 && m_len < 3; n++) nav_step(m_fx, m_fy);
    chk("grow_len3", (bus.length >= 3) ? 1 : 0, 1);
    for (int n = 0; n < 200 && m_state == 1 && !(m_hx == 3 && m_hy == 10); n++) nav_step(3, 10);
    query(3, 10); cycle(0, 0, 0, 0);
    chk("nav_head", bus.pix_head, 1);
    case (m_dir)
      1: cycle(0, 0, 0, 1);
      2: begin cycle(0, 0, 1, 0); tick1(); cycle(0, 0, 1, 0); tick1(); end
      3: cycle(0, 0, 1, 0);
      default: ;
    endcase
    repeat (3) tick1();
    chk("straight_playing", bus.playing, 1);
    repeat (3) begin cycle(0, 0, 1, 0); tick1(); end
    chk("self_over", bus.game_over, 1);

    // start + tick in OVER: start wins, no step
    q_px = 322; q_py = 242;
    cycle(1, 1, 0, 0);
    cycle(0, 0, 0, 0);
    chk("st_tick_playing", bus.playing, 1);
    chk("st_tick_head", bus.pix_head, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", n_chk);
    $fatal(1, "timeout");
  end
endmodule
